// File: rtl/sdr_burst_sequencer.sv
// sdr_burst_sequencer: single-command sequencer for the exported SDRAM burst port.
// A read burst line is unpacked into a WORD_W-bit valid/ready stream. A write line
// is packed from a WORD_W-bit valid/ready stream before its burst is issued.
// Optional watchdog on the end strobes: define SDR_SEQ_TIMEOUT_EN.
module sdr_burst_sequencer #(
   parameter int LINE_W      = 2048,
   parameter int WORD_W      = 32,
   parameter int NWORDS      = LINE_W / WORD_W,
   parameter int ADDR_W      = 32,
   parameter int NELEM_W     = 30,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               sdr_clk,
   input  logic               sdr_reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [NELEM_W-1:0] cmd_nelems,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [WORD_W-1:0]  rd_data,
   output logic               rd_last,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [WORD_W-1:0]  wr_data,
   output logic               sdr_readstart,
   output logic               sdr_writestart,
   output logic [ADDR_W-1:0]  sdr_baseaddr,
   output logic [NELEM_W-1:0] sdr_nelems,
   output logic [LINE_W-1:0]  sdr_writedata,
   input  logic [LINE_W-1:0]  sdr_readdata,
   input  logic               sdr_readend,
   input  logic               sdr_writeend,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int CNT_W = $clog2(NWORDS + 1);

   // Elaboration-time guard against inconsistent parameter sets.
   if ((LINE_W % WORD_W) != 0 || NWORDS != LINE_W / WORD_W || TIMEOUT_CYC < 1) begin : g_cfg_check
      $error("sdr_burst_sequencer: invalid parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_STREAM, S_WR_FILL, S_WR_REQ, S_WR_WAIT, S_DONE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    n_q;
   logic [CNT_W-1:0]    idx;
   logic [CNT_W-1:0]    n_cmd;
   logic [LINE_W-1:0]   rline;
   logic                rd_capture;
   logic                rd_fire;

   // Words actually moved: the request is clipped to one burst line.
   assign n_cmd = (cmd_nelems > NELEM_W'(NWORDS)) ? CNT_W'(NWORDS) : cmd_nelems[CNT_W-1:0];

   assign rd_capture = (state == S_RD_REQ || state == S_RD_WAIT) && sdr_readend;
   assign rd_fire    = (state == S_RD_STREAM) && rd_valid && rd_ready;

`ifdef SDR_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wait_cnt;
`else
   assign err = 1'b0;
`endif

   // Read line buffer: loaded on the read end strobe, shifted down one word per handshake.
   // NOTE: this wide buffer is always overwritten before it is read, so it is left without reset.
   always_ff @(posedge sdr_clk) begin
      if (rd_capture)
         rline <= sdr_readdata >> WORD_W;
      else if (rd_fire)
         rline <= rline >> WORD_W;
   end

   // Command FSM with all outputs registered.
   // NOTE: every register here uses <= so each next value is computed from pre-edge state only.
   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         state          <= S_IDLE;
         cmd_ready      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         sdr_readstart  <= 1'b0;
         sdr_writestart <= 1'b0;
         sdr_baseaddr   <= '0;
         sdr_nelems     <= '0;
         sdr_writedata  <= '0;
         rd_valid       <= 1'b0;
         rd_data        <= '0;
         rd_last        <= 1'b0;
         wr_ready       <= 1'b0;
         addr_q         <= '0;
         n_q            <= '0;
         idx            <= '0;
`ifdef SDR_SEQ_TIMEOUT_EN
         err            <= 1'b0;
         wait_cnt       <= '0;
`endif
      end else begin
         sdr_readstart  <= 1'b0;
         sdr_writestart <= 1'b0;
         done           <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  addr_q    <= cmd_addr;
                  n_q       <= n_cmd;
                  idx       <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef SDR_SEQ_TIMEOUT_EN
                  err       <= 1'b0;
`endif
                  if (n_cmd == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (cmd_write) begin
                     state         <= S_WR_FILL;
                     wr_ready      <= 1'b1;
                     sdr_writedata <= '0;
                  end else begin
                     state         <= S_RD_REQ;
                     sdr_readstart <= 1'b1;
                     sdr_baseaddr  <= cmd_addr;
                     sdr_nelems    <= NELEM_W'(n_cmd);
                  end
               end
            end
            S_RD_REQ, S_RD_WAIT: begin
               if (sdr_readend) begin
                  state        <= S_RD_STREAM;
                  rd_valid     <= 1'b1;
                  rd_data      <= sdr_readdata[WORD_W-1:0];
                  rd_last      <= (n_q == CNT_W'(1));
                  idx          <= '0;
                  sdr_baseaddr <= '0;
                  sdr_nelems   <= '0;
               end else if (state == S_RD_REQ) begin
                  state <= S_RD_WAIT;
`ifdef SDR_SEQ_TIMEOUT_EN
                  wait_cnt <= '0;
               end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  state        <= S_DONE;
                  done         <= 1'b1;
                  err          <= 1'b1;
                  sdr_baseaddr <= '0;
                  sdr_nelems   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
`endif
               end
            end
            S_RD_STREAM: begin
               if (rd_ready) begin
                  if (idx == n_q - CNT_W'(1)) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     rd_data  <= '0;
                  end else begin
                     idx     <= idx + CNT_W'(1);
                     rd_data <= rline[WORD_W-1:0];
                     rd_last <= (idx + CNT_W'(2) == n_q);
                  end
               end
            end
            S_WR_FILL: begin
               if (wr_valid) begin
                  sdr_writedata[WORD_W*idx +: WORD_W] <= wr_data;
                  if (idx == n_q - CNT_W'(1)) begin
                     state          <= S_WR_REQ;
                     wr_ready       <= 1'b0;
                     sdr_writestart <= 1'b1;
                     sdr_baseaddr   <= addr_q;
                     sdr_nelems     <= NELEM_W'(n_q);
                  end else begin
                     idx <= idx + CNT_W'(1);
                  end
               end
            end
            S_WR_REQ, S_WR_WAIT: begin
               if (sdr_writeend) begin
                  state        <= S_DONE;
                  done         <= 1'b1;
                  sdr_baseaddr <= '0;
                  sdr_nelems   <= '0;
               end else if (state == S_WR_REQ) begin
                  state <= S_WR_WAIT;
`ifdef SDR_SEQ_TIMEOUT_EN
                  wait_cnt <= '0;
               end else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  state        <= S_DONE;
                  done         <= 1'b1;
                  err          <= 1'b1;
                  sdr_baseaddr <= '0;
                  sdr_nelems   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + TO_W'(1);
`endif
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
